// File: rtl/elevator_scheduler.sv
// SCAN elevator car controller: serves latched floor requests, steps the car one floor per
// travel period, holds the door open while clearing the served request.
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       hold,
    output logic [7:0] clr,
    output logic [2:0] floor,
    output logic       dir,
    output logic       moving,
    output logic       door_open
);
    localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TRAVEL_RELOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_RELOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [2:0]    TOP_FLOOR     = 3'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

    state_t          state, nxt_state;
    logic [2:0]      nxt_floor;
    logic            nxt_dir;
    logic [TW-1:0]   timer, nxt_timer;
    logic [7:0]      reqm;
    logic [2:0]      eval_floor;
    logic            at_end, step_now, here, above, below;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            floor <= 3'd0;
            dir   <= 1'b1;
            timer <= '0;
        end else begin
            state <= nxt_state;
            floor <= nxt_floor;
            dir   <= nxt_dir;
            timer <= nxt_timer;
        end
    end

    // The arrival decision looks at the floor the car is about to reach, so the car
    // continues, stops or reverses on the same edge it steps.
    always_comb begin
        for (int i = 0; i < 8; i++) reqm[i] = (i < NUM_FLOORS) && req[i];
        at_end     = dir ? (floor == TOP_FLOOR) : (floor == 3'd0);
        step_now   = (state == MOVING) && (timer == '0);
        eval_floor = floor;
        if (step_now && !at_end) eval_floor = dir ? floor + 3'd1 : floor - 3'd1;
        here  = 1'b0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (3'(i) == eval_floor) here  = here  | reqm[i];
            if (3'(i) >  eval_floor) above = above | reqm[i];
            if (3'(i) <  eval_floor) below = below | reqm[i];
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_floor = floor;
        nxt_dir   = dir;
        nxt_timer = timer;
        if (state == DOOR) begin
            if (hold)              nxt_timer = DOOR_RELOAD;
            else if (timer == '0)  nxt_state = IDLE;
            else                   nxt_timer = timer - 1'b1;
        end else if (state == MOVING && !step_now) begin
            nxt_timer = timer - 1'b1;
        end else begin
            // IDLE, or MOVING at the end of a travel period
            nxt_floor = eval_floor;
            if (here) begin
                nxt_state = DOOR;
                nxt_timer = DOOR_RELOAD;
            end else if (dir ? above : below) begin
                nxt_state = MOVING;
                nxt_timer = TRAVEL_RELOAD;
            end else if (dir ? below : above) begin
                nxt_state = MOVING;
                nxt_dir   = ~dir;
                nxt_timer = TRAVEL_RELOAD;
            end else begin
                nxt_state = IDLE;
                nxt_timer = '0;
            end
        end
    end

    always_comb begin
        clr       = 8'h00;
        moving    = (state == MOVING);
        door_open = (state == DOOR);
        if (state == DOOR) clr[floor] = 1'b1;
    end
endmodule
